// File: rtl/router_out_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : router_out_arbiter
// Purpose  : Round-robin arbiter plus single-entry output register for one
//            output port of the tree NoC router. Three sources (parent,
//            child1, child2) compete for the port. The winning packet is
//            captured into the output register and held until it is
//            accepted downstream. The block also counts delivered packets
//            and flags requests from the blocked (U-turn) source.
// Ports    :
//   clk        in   1              rising-edge clock
//   rst        in   1              synchronous active-high reset
//   in_valid   in   3              request per source (0=parent,1=child1,2=child2)
//   in_data    in   3*WIDTH_packet packet per source, slice i at i*WIDTH_packet
//   in_ready   out  3              one-hot accept for the granted source
//   out_valid  out  1              output register holds a packet
//   out_data   out  WIDTH_packet   held packet
//   out_ready  in   1              downstream accept
//   out_src    out  2              source index of the held packet
//   pkt_count  out  CNT_W          packets delivered downstream (wrapping)
//   uturn_err  out  1              sticky: blocked source raised a request
// Revision : 1.0 - initial release
// ============================================================================
module router_out_arbiter #(
  parameter int WIDTH_packet = 14,
  parameter int BLOCK_IDX    = 3,
  parameter int CNT_W        = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [2:0]                in_valid,
  input  logic [3*WIDTH_packet-1:0] in_data,
  output logic [2:0]                in_ready,
  output logic                      out_valid,
  output logic [WIDTH_packet-1:0]   out_data,
  input  logic                      out_ready,
  output logic [1:0]                out_src,
  output logic [CNT_W-1:0]          pkt_count,
  output logic                      uturn_err
);

  // Output register occupancy
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]              r_state;
  logic [WIDTH_packet-1:0] r_data;
  logic [1:0]              r_src;
  logic [1:0]              r_rr_ptr;
  logic [CNT_W-1:0]        r_pkt_count;
  logic                    r_uturn_err;

  logic [2:0]              w_block_mask;
  logic [2:0]              w_elig;
  logic                    w_any;
  logic                    w_can_load;
  logic                    w_grant;
  logic                    w_deliver;
  logic [1:0]              w_first;
  logic [1:0]              w_second;
  logic [1:0]              w_third;
  logic [1:0]              w_win;
  logic [WIDTH_packet-1:0] w_win_data;
  logic [WIDTH_packet-1:0] w_slice [3];

  // Mask of the source that may never be granted on this port. When
  // BLOCK_IDX is 3 no bit matches and every source is eligible.
  generate
    for (genvar i = 0; i < 3; i++) begin : g_mask
      assign w_block_mask[i] = (BLOCK_IDX == i);
    end
  endgenerate

  generate
    for (genvar i = 0; i < 3; i++) begin : g_slice
      assign w_slice[i] = in_data[i*WIDTH_packet +: WIDTH_packet];
    end
  endgenerate

  assign w_elig     = in_valid & ~w_block_mask;
  assign w_any      = |w_elig;
  assign w_can_load = (r_state == ST_EMPTY) || out_ready;
  assign w_deliver  = (r_state == ST_FULL) && out_ready;

  // Search order starts one past the last granted source and wraps.
  always_comb begin
    w_first  = 2'd0;
    w_second = 2'd1;
    w_third  = 2'd2;
    case (r_rr_ptr)
      2'd0: begin
        w_first  = 2'd1;
        w_second = 2'd2;
        w_third  = 2'd0;
      end
      2'd1: begin
        w_first  = 2'd2;
        w_second = 2'd0;
        w_third  = 2'd1;
      end
      default: begin
        w_first  = 2'd0;
        w_second = 2'd1;
        w_third  = 2'd2;
      end
    endcase
  end

  always_comb begin
    w_win = 2'd0;
    if (w_elig[w_first]) begin
      w_win = w_first;
    end else if (w_elig[w_second]) begin
      w_win = w_second;
    end else if (w_elig[w_third]) begin
      w_win = w_third;
    end
  end

  always_comb begin
    case (w_win)
      2'd0:    w_win_data = w_slice[0];
      2'd1:    w_win_data = w_slice[1];
      default: w_win_data = w_slice[2];
    endcase
  end

  // Grant is suppressed during reset so that no source believes a packet
  // was accepted on an edge where the register is being cleared.
  always_comb begin
    in_ready = 3'b000;
    if (!rst && w_can_load && w_any) begin
      in_ready[w_win] = 1'b1;
    end
  end

  // in_ready only ever points at an eligible (hence valid) source, so any
  // asserted grant is a completed source transfer.
  assign w_grant = |in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_data      <= '0;
      r_src       <= 2'd0;
      r_rr_ptr    <= 2'd2;
      r_pkt_count <= '0;
      r_uturn_err <= 1'b0;
    end else begin
      if (w_grant) begin
        // Load wins over drain: a simultaneous delivery and new load
        // replaces the register contents and keeps it full.
        r_state  <= ST_FULL;
        r_data   <= w_win_data;
        r_src    <= w_win;
        r_rr_ptr <= w_win;
      end else if (w_deliver) begin
        r_state <= ST_EMPTY;
      end

      if (w_deliver) begin
        r_pkt_count <= r_pkt_count + 1'b1;
      end

      if (|(in_valid & w_block_mask)) begin
        r_uturn_err <= 1'b1;
      end
    end
  end

  assign out_valid = (r_state == ST_FULL);
  assign out_data  = r_data;
  assign out_src   = r_src;
  assign pkt_count = r_pkt_count;
  assign uturn_err = r_uturn_err;

endmodule
`default_nettype wire
